// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t    : loader FSM encoding (3 bits)
//   LEN_BYTES  : bytes in the little-endian length header
//   WORD_BYTES : bytes per instruction word
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  // States in which a load is in flight.
  function automatic logic is_busy(input state_t s);
    return (s == LEN) || (s == DATA) || (s == WRITE) || (s == CHK);
  endfunction

  // States in which a start pulse is honoured.
  function automatic logic can_start(input state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: byte stream in, instruction-memory write port out.
//   byte_in/byte_valid : stream data from the source
//   byte_ready         : loader accepts a byte this cycle
//   imem_we/addr/wdata : one-cycle word write into instruction RAM
// master = stream source and memory side, slave = the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_packer.sv
// Assembles WORD_BYTES bytes into a little-endian 32-bit word.
//   clk, reset : clock, synchronous active-low reset
//   clear      : rewind the byte index to 0 (word contents kept)
//   load       : accept byte_in into the current lane
//   word       : assembled word register
//   word_full  : this load writes the last lane of the word
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (load) begin
      word[{idx, 3'b000} +: 8] <= byte_in;
      idx                      <= idx + 2'd1;  // wraps to lane 0 after a full word
    end
  end

  assign word_full = load && (idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses  len[2] | words[4*N] | xor[1]  from a
// byte stream, writes words to consecutive addresses, and releases the core
// only after a load whose checksum matches.
//   clk, reset : clock, synchronous active-low reset
//   start      : begin a load (honoured in IDLE/DONE/ERR)
//   bus        : stream handshake + memory write port (slave side)
//   core_hold  : 1 keeps the core in reset
//   busy       : load in flight
//   done / err : load result, held until the next start
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256  // must not exceed 2**ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t            state, next_state;
  logic [15:0]       n_words;
  logic [15:0]       wcnt;
  logic              len_idx;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              byte_ready_c;
  logic              xfer;
  logic              enter_len;
  logic              word_full;
  logic [31:0]       word;
  logic [15:0]       n_next;

  assign xfer      = bus.byte_valid && byte_ready_c;
  assign enter_len = start && can_start(state);
  // Complete header as it will look once the current byte lands.
  assign n_next    = {bus.byte_in, n_words[7:0]};

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (enter_len),
    .load      ((state == DATA) && xfer),
    .byte_in   (bus.byte_in),
    .word      (word),
    .word_full (word_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) next_state = LEN;
      LEN: begin
        if (xfer && (len_idx == 1'(LEN_BYTES - 1))) begin
          if ((n_next == 16'd0) || (n_next > 16'(MAX_WORDS))) next_state = ERR;
          else                                                next_state = DATA;
        end
      end
      DATA:  if (word_full) next_state = WRITE;
      WRITE: next_state = ((wcnt + 16'd1) == n_words) ? CHK : DATA;
      CHK: begin
        if (xfer) next_state = (bus.byte_in == csum) ? DONE : ERR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: byte_ready is the only combinational output.
  always_comb begin
    byte_ready_c = (state == LEN) || (state == DATA) || (state == CHK);
  end

  // Registered outputs follow next_state so they line up with the state
  // they describe; counters and checksum live here too.
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      core_hold <= 1'b1;
      n_words   <= '0;
      wcnt      <= '0;
      len_idx   <= 1'b0;
      csum      <= '0;
    end else begin
      we_q      <= (next_state == WRITE);
      busy      <= is_busy(next_state);
      done      <= (next_state == DONE);
      err       <= (next_state == ERR);
      core_hold <= (next_state != DONE);

      if (enter_len) begin
        addr_q  <= '0;
        wcnt    <= '0;
        len_idx <= 1'b0;
        csum    <= '0;
      end

      if ((state == LEN) && xfer) begin
        if (len_idx == 1'b0) n_words[7:0]  <= bus.byte_in;
        else                 n_words[15:8] <= bus.byte_in;
        len_idx <= ~len_idx;
      end

      if ((state == DATA) && xfer) csum <= csum ^ bus.byte_in;

      if (state == WRITE) begin
        addr_q <= addr_q + 1'b1;
        wcnt   <= wcnt + 16'd1;
      end
    end
  end

  assign bus.byte_ready = byte_ready_c;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;

endmodule
